// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter_pkg : shared state encoding and defaults for the arbiter.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_tx_arbiter_pkg;

  localparam int c_DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2
  } arb_state_t;

  // Index of the winner in a two-way one-hot grant.
  function automatic logic onehot2_to_idx(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester handshakes and UART transmit-side signals.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface uart_tx_arbiter_if;

  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] txdata;
  logic       txbegin;
  logic       txbusy;
  logic       owner;
  logic       busy;
  logic       timeout;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, txbusy,
    output req0_ready, req1_ready, txdata, txbegin, owner, busy, timeout
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, txbusy,
    input  req0_ready, req1_ready, txdata, txbegin, owner, busy, timeout
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter2 : two-way combinational grant; tie policy set by               |
// | UART_TX_ARB_ROUNDROBIN_EN (round-robin) or fixed priority to requester 0.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arbiter2 (
  input  wire logic [1:0] valid,
  input  wire logic       enable,
  input  wire logic       last,
  output logic      [1:0] grant
);

  logic [1:0] w_req;

  assign w_req = enable ? valid : 2'b00;

`ifdef UART_TX_ARB_ROUNDROBIN_EN
  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant = w_req;
    if (&w_req) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic w_unused_last;

  assign w_unused_last = last;

  always_comb begin
    grant = w_req;
    if (&w_req) begin
      grant = 2'b01;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter : shares one UART transmitter between two byte producers,  |
// | with a START timeout. Tie policy: UART_TX_ARB_ROUNDROBIN_EN (rr_arbiter2). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  arb_state_t         r_state;
  logic [7:0]         r_txdata;
  logic               r_txbegin;
  logic               r_owner;
  logic               r_timeout;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_enable;
  logic [1:0]         w_grant;
  logic               w_grant_idx;
  logic [7:0]         w_grant_data;

  // Holding off while txbusy is high lets a frame started before a reset finish.
  assign w_enable = (r_state == ST_IDLE) && !bus.txbusy;

  rr_arbiter2 u_rr_arbiter2 (
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .enable (w_enable),
    .last   (r_owner),
    .grant  (w_grant)
  );

  assign w_grant_idx  = onehot2_to_idx(w_grant);
  assign w_grant_data = w_grant_idx ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_txdata  <= 8'h00;
      r_txbegin <= 1'b0;
      r_owner   <= 1'b1;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_txdata  <= w_grant_data;
            r_owner   <= w_grant_idx;
            r_txbegin <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          // An acknowledge on the last allowed cycle still counts as accepted.
          if (bus.txbusy) begin
            r_txbegin <= 1'b0;
            r_state   <= ST_SEND;
          end else if (r_cnt == c_CNT_LAST) begin
            r_txbegin <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (!bus.txbusy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_txbegin <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];
  assign bus.txdata     = r_txdata;
  assign bus.txbegin    = r_txbegin;
  assign bus.owner      = r_owner;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.timeout    = r_timeout;

  a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.req0_ready || bus.req1_ready) |-> (r_state == ST_IDLE && !bus.txbusy));

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.req0_ready && bus.req1_ready));

  a_txbegin_in_start: assert property (@(posedge clk) disable iff (!rst_n)
    r_txbegin == (r_state == ST_START));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    r_cnt <= c_CNT_LAST);

endmodule
`default_nettype wire
